// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep sequencer: drives every input vector to a small gate DUT and tallies pass/fail.
// Optional build macro SWEEP_STOP_ON_FAIL_EN: end the sweep at the first failing vector.
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  input  logic             expect_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             all_pass,
  output logic [N_IN-1:0]  first_fail
);

  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} stateT;

  stateT             state, nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic              vecMatch, lastVec, stopHere;

  // Case equality so an X/Z on either side counts as a failure in 4-state sim.
  assign vecMatch = (dut_out === expect_in);
  assign lastVec  = (dut_in == '1);

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign stopHere = !vecMatch;
`else
  assign stopHere = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) nextState = S_SETTLE;
      S_SETTLE:       if (waitCnt == WAIT_W'(1)) nextState = S_CHECK;
      S_CHECK:        nextState = (lastVec || stopHere) ? S_DONE : S_SETTLE;
      default:        nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in     <= '0;
      waitCnt    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: if (start) begin
          dut_in     <= '0;
          waitCnt    <= WAIT_INIT;
          pass_cnt   <= '0;
          fail_cnt   <= '0;
          first_fail <= '0;
        end
        S_SETTLE: if (waitCnt != WAIT_W'(1)) waitCnt <= waitCnt - WAIT_W'(1);
        S_CHECK: begin
          if (vecMatch) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            if (fail_cnt == '0) first_fail <= dut_in;
          end
          // dut_in holds on the final (or stopping) vector so it stays visible in DONE.
          if (!lastVec && !stopHere) begin
            dut_in  <= dut_in + N_IN'(1);
            waitCnt <= WAIT_INIT;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == S_SETTLE) || (state == S_CHECK);
  assign done     = (state == S_DONE);
  assign all_pass = done && (fail_cnt == '0);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: edge-count reference model checked every cycle, plus literal sweep scenarios.
module tb_gate_sweep_ctrl;
  localparam int N = 2, S = 1, V = 4, CW = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [N-1:0] dut_in, first_fail;
  logic dutOut, expectIn, busy, done, all_pass;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic tt [V];

  int errors = 0, checks = 0;

  gate_sweep_ctrl #(.N_IN(N), .SETTLE(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in),
    .dut_out(dutOut), .expect_in(expectIn), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .all_pass(all_pass),
    .first_fail(first_fail));

  always #5 clk = ~clk;

  assign dutOut   = tt[dut_in];
  assign expectIn = dut_in[1] & ~dut_in[0];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: a sweep is just k edges since the accepted start; each vector owns S+1 edges.
  logic ttSnap [V];
  bit   active = 1'b0;
  int   k = 0, endK = 0;

  function automatic bit vecOk(input int v);
    logic [1:0] vv;
    vv = v[1:0];
    return ttSnap[v] === (vv[1] & ~vv[0]);
  endfunction

  function automatic int sweepVecs();
`ifdef SWEEP_STOP_ON_FAIL_EN
    for (int v = 0; v < V; v++) if (!vecOk(v)) return v + 1;
`endif
    return V;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 1'b0; k = 0;
    end else if (start && (!active || k >= endK)) begin
      active = 1'b1; k = 0;
      for (int v = 0; v < V; v++) ttSnap[v] = tt[v];
      endK = sweepVecs() * (S + 1);
    end else if (active && k < endK) begin
      k++;
    end
  end

  always @(negedge clk) begin
    int c, nv, p, f, ff, eDin;
    bit eDone;
    c = 0; nv = 0; p = 0; f = 0; ff = 0; eDin = 0; eDone = 0;
    if (active) begin
      nv = endK / (S + 1);
      c  = k / (S + 1);
      if (c > nv) c = nv;
      for (int v = 0; v < c; v++) begin
        if (vecOk(v)) p++;
        else begin
          if (f == 0) ff = v;
          f++;
        end
      end
      eDone = (k >= endK);
      eDin  = eDone ? nv - 1 : k / (S + 1);
    end
    chk("dut_in",     32'(dut_in),     32'(eDin));
    chk("busy",       32'(busy),       32'(active && !eDone));
    chk("done",       32'(done),       32'(eDone));
    chk("pass_cnt",   32'(pass_cnt),   32'(p));
    chk("fail_cnt",   32'(fail_cnt),   32'(f));
    chk("first_fail", 32'(first_fail), 32'(ff));
    chk("all_pass",   32'(all_pass),   32'(eDone && f == 0));
  end

  task automatic setTt(input logic [3:0] t);
    for (int v = 0; v < V; v++) tt[v] = t[v];
  endtask

  // Pulse start for one edge, then count edges until done (bounded).
  task automatic pulseStart();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic waitDone(input int already, output int n);
    n = already;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    setTt(4'b0100);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Correct DUT z = a & ~b
    pulseStart();
    waitDone(0, n);
    chk("good_latency", 32'(n), 32'd8);
    chk("good_pass", 32'(pass_cnt), 32'd4);
    chk("good_fail", 32'(fail_cnt), 32'd0);
    chk("good_allpass", 32'(all_pass), 32'd1);
    chk("good_dutin", 32'(dut_in), 32'd3);

    // Faulty DUT z = a & b
    @(negedge clk); #1 setTt(4'b1000);
    pulseStart();
    waitDone(0, n);
`ifdef SWEEP_STOP_ON_FAIL_EN
    chk("bad_latency", 32'(n), 32'd6);
    chk("bad_pass", 32'(pass_cnt), 32'd2);
    chk("bad_fail", 32'(fail_cnt), 32'd1);
    chk("bad_dutin", 32'(dut_in), 32'd2);
`else
    chk("bad_latency", 32'(n), 32'd8);
    chk("bad_pass", 32'(pass_cnt), 32'd2);
    chk("bad_fail", 32'(fail_cnt), 32'd2);
    chk("bad_firstfail", 32'(first_fail), 32'd2);
`endif
    chk("bad_allpass", 32'(all_pass), 32'd0);

    // Start re-pulsed around edge +3 is ignored
    @(negedge clk); #1 setTt(4'b0100);
    pulseStart();
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waitDone(3, n);
    chk("restart_latency", 32'(n), 32'd8);
    chk("restart_pass", 32'(pass_cnt), 32'd4);

    // Reset after edge +5 aborts the sweep
    pulseStart();
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0; #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dutin", 32'(dut_in), 32'd0);
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    pulseStart();
    waitDone(0, n);
    chk("post_rst_latency", 32'(n), 32'd8);
    chk("post_rst_pass", 32'(pass_cnt), 32'd4);

    // Randomized truth tables (including X entries), start traffic and occasional resets
    for (int it = 0; it < 20; it++) begin
      @(negedge clk); #1;
      for (int v = 0; v < V; v++)
        case ($urandom_range(0, 5))
          0:       tt[v] = 1'bx;
          1, 2:    tt[v] = 1'b1;
          default: tt[v] = 1'b0;
        endcase
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk); #1;
        start = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 39) == 0) begin
          rst_n = 1'b0;
          @(negedge clk); #1 rst_n = 1'b1;
        end
      end
      @(negedge clk); #1 start = 1'b0;
      repeat (12) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
